// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter for the write side of one shared FIFO.
// The grant is held for a bounded burst so that no requester can starve the others.
module fifo_wr_arbiter #(
  parameter int NREQ     = 4,
  parameter int DWIDTH   = 8,
  parameter int MAXBURST = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DWIDTH-1:0]   data,
  output logic [NREQ-1:0]          ack,
  output logic [NREQ-1:0]          grant,
  input  logic                     fifo_full,
  output logic                     fifo_inc,
  output logic [DWIDTH-1:0]        fifo_din,
  output logic                     busy
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, XFER, REARB} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [PW-1:0]   last_q, last_d;
  logic [3:0]      count_q, count_d;

  logic            found;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   cand_idx;
  logic [NREQ-1:0] win_onehot;
  int              cand;
  logic            req_own;
  logic            accept;
  logic            burst_done;

  // Pointer resets to NREQ-1 so requester 0 wins the first arbitration.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= PW'(NREQ - 1);
      count_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    found      = 1'b0;
    win_idx    = last_q;
    cand       = 0;
    cand_idx   = '0;
    win_onehot = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand     = (int'(last_q) + k) % NREQ;
      cand_idx = PW'(cand);
      if (!found && req[cand_idx]) begin
        found   = 1'b1;
        win_idx = cand_idx;
      end
    end
    win_onehot[win_idx] = 1'b1;
  end

  // Grant is one-hot, so masking req by it yields the owner's request bit.
  always_comb begin
    req_own    = |(grant_q & req);
    accept     = (state_q == XFER) && req_own && !fifo_full;
    burst_done = (count_q == 4'(MAXBURST - 1));
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    count_d = count_q;
    unique case (state_q)
      IDLE, REARB: begin
        if (found) begin
          state_d = XFER;
          grant_d = win_onehot;
          last_d  = win_idx;
          count_d = '0;
        end else begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      XFER: begin
        if (!req_own) begin
          state_d = REARB;
          grant_d = '0;
        end else if (accept) begin
          count_d = count_q + 4'd1;
          if (burst_done) begin
            state_d = REARB;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    grant    = grant_q;
    fifo_inc = accept;
    ack      = accept ? grant_q : '0;
    busy     = (state_q != IDLE);
    fifo_din = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) fifo_din = data[i*DWIDTH +: DWIDTH];
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: per-scenario tasks check grant/ack timing,
// and a scoreboard of per-requester expected words is checked whenever the FIFO is written.
module tb_fifo_wr_arbiter;

  localparam int NREQ     = 4;
  localparam int DWIDTH   = 8;
  localparam int MAXBURST = 4;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        req;
  logic [NREQ*DWIDTH-1:0] data;
  logic [NREQ-1:0]        ack;
  logic [NREQ-1:0]        grant;
  logic                   fifo_full;
  logic                   fifo_inc;
  logic [DWIDTH-1:0]      fifo_din;
  logic                   busy;

  int checks = 0;
  int errors = 0;

  logic [DWIDTH-1:0] src   [NREQ][$];
  logic [DWIDTH-1:0] exp_q [NREQ][$];
  logic [DWIDTH-1:0] mon_word;

  fifo_wr_arbiter #(.NREQ(NREQ), .DWIDTH(DWIDTH), .MAXBURST(MAXBURST)) dut (
    .clock(clock), .reset(reset), .req(req), .data(data), .ack(ack), .grant(grant),
    .fifo_full(fifo_full), .fifo_inc(fifo_inc), .fifo_din(fifo_din), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scoreboard: every FIFO write must carry the oldest outstanding word of the acked requester.
  always @(negedge clock) begin
    if (!reset) begin
      checks++;
      if (fifo_inc && fifo_full) begin
        errors++;
        $display("[TB] FAIL overflow: fifo_inc=%0b while fifo_full=%0b", fifo_inc, fifo_full);
      end
      if (fifo_inc) begin
        checks++;
        if (!$onehot(ack)) begin
          errors++;
          $display("[TB] FAIL ack_onehot: ack=%b with fifo_inc high", ack);
        end else begin
          for (int i = 0; i < NREQ; i++) begin
            if (ack[i]) begin
              checks++;
              if (exp_q[i].size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_word: requester %0d got din=%h, nothing pending", i, fifo_din);
              end else begin
                mon_word = exp_q[i].pop_front();
                if (fifo_din !== mon_word) begin
                  errors++;
                  $display("[TB] FAIL fifo_din: requester %0d din=%h expected %h", i, fifo_din, mon_word);
                end
              end
              if (src[i].size() != 0) void'(src[i].pop_front());
            end
          end
        end
      end else begin
        checks++;
        if (ack !== '0) begin
          errors++;
          $display("[TB] FAIL ack_without_inc: ack=%b expected 0000", ack);
        end
      end
    end
  end

  task automatic push_word(input int r, input logic [DWIDTH-1:0] w);
    src[r].push_back(w);
    exp_q[r].push_back(w);
  endtask

  task automatic clear_queues();
    for (int i = 0; i < NREQ; i++) begin
      src[i].delete();
      exp_q[i].delete();
    end
  endtask

  // Drive requester inputs just after a rising edge, then return just after the falling edge.
  task automatic cycle(input logic full);
    @(posedge clock);
    #1;
    fifo_full = full;
    for (int i = 0; i < NREQ; i++) begin
      req[i] = (src[i].size() != 0);
      data[i*DWIDTH +: DWIDTH] = (src[i].size() != 0) ? src[i][0] : '0;
    end
    @(negedge clock);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      cycle(1'b0);
      n++;
      done = !busy;
      for (int i = 0; i < NREQ; i++) if (src[i].size() != 0) done = 1'b0;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL %s_drain: still busy=%0b after %0d cycles, required idle", name, busy, n);
    end
    for (int i = 0; i < NREQ; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin
        errors++;
        $display("[TB] FAIL %s_pending: requester %0d has %0d words not written, required 0", name, i, exp_q[i].size());
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    fifo_full = 1'b0;
    req = '0;
    data = '0;
    #23;
    checks++;
    if (grant !== '0 || ack !== '0 || fifo_inc !== 1'b0 || busy !== 1'b0 || fifo_din !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: grant=%b ack=%b inc=%b busy=%b din=%h, required all 0",
               grant, ack, fifo_inc, busy, fifo_din);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_idle();
    for (int c = 0; c < 10; c++) begin
      cycle(1'b0);
      checks++;
      if (busy !== 1'b0 || grant !== '0 || fifo_inc !== 1'b0 || fifo_din !== '0) begin
        errors++;
        $display("[TB] FAIL idle_c%0d: busy=%b grant=%b inc=%b din=%h, required all 0",
                 c, busy, grant, fifo_inc, fifo_din);
      end
    end
  endtask

  // All four requesting: bursts of MAXBURST in order 0,1,2,3,0 with a one-cycle gap between.
  task automatic test_round_robin();
    logic [NREQ-1:0] exp_g;
    clear_queues();
    for (int r = 0; r < NREQ; r++)
      for (int k = 0; k < 8; k++) push_word(r, DWIDTH'(r*16 + k));
    for (int c = 1; c <= 25; c++) begin
      cycle(1'b0);
      if (c == 1 || ((c - 2) % 5) == 4) exp_g = '0;
      else exp_g = NREQ'(1) << (((c - 2) / 5) % NREQ);
      checks++;
      if (grant !== exp_g || ack !== exp_g || fifo_inc !== (exp_g != '0)) begin
        errors++;
        $display("[TB] FAIL rr_c%0d: grant=%b ack=%b inc=%b, required grant=%b ack=%b",
                 c, grant, ack, fifo_inc, exp_g, exp_g);
      end
    end
    drain("rr");
  endtask

  task automatic test_early_release();
    logic [NREQ-1:0] exp_g, exp_a;
    clear_queues();
    push_word(1, 8'h31); push_word(1, 8'h32);
    push_word(3, 8'h71); push_word(3, 8'h72); push_word(3, 8'h73);
    for (int c = 1; c <= 10; c++) begin
      cycle(1'b0);
      exp_g = (c >= 2 && c <= 4) ? 4'b0010 : (c >= 6 && c <= 9) ? 4'b1000 : 4'b0000;
      exp_a = (c == 2 || c == 3) ? 4'b0010 : (c >= 6 && c <= 8) ? 4'b1000 : 4'b0000;
      checks++;
      if (grant !== exp_g || ack !== exp_a || busy !== (c >= 2)) begin
        errors++;
        $display("[TB] FAIL early_c%0d: grant=%b ack=%b busy=%b, required grant=%b ack=%b busy=%b",
                 c, grant, ack, busy, exp_g, exp_a, (c >= 2));
      end
    end
    drain("early");
  endtask

  task automatic test_single();
    logic [NREQ-1:0] exp_g;
    logic exp_inc;
    clear_queues();
    for (int k = 0; k < 6; k++) push_word(0, 8'hA5);
    for (int c = 1; c <= 11; c++) begin
      cycle(1'b0);
      exp_g   = ((c >= 2 && c <= 5) || (c >= 7 && c <= 9)) ? 4'b0001 : 4'b0000;
      exp_inc = (c >= 2 && c <= 5) || c == 7 || c == 8;
      checks++;
      if (grant !== exp_g || fifo_inc !== exp_inc || busy !== (c >= 2 && c <= 10) ||
          (exp_inc && fifo_din !== 8'hA5)) begin
        errors++;
        $display("[TB] FAIL single_c%0d: grant=%b inc=%b busy=%b din=%h, required grant=%b inc=%b din=a5",
                 c, grant, fifo_inc, busy, fifo_din, exp_g, exp_inc);
      end
    end
    drain("single");
  endtask

  // FIFO full for three cycles after the second word: grant and stalled word must hold.
  task automatic test_back_pressure();
    logic [NREQ-1:0] exp_g, exp_a;
    clear_queues();
    for (int k = 0; k < 4; k++) push_word(2, DWIDTH'(8'hC0 + k));
    for (int c = 1; c <= 10; c++) begin
      cycle(c >= 4 && c <= 6);
      exp_g = (c >= 2 && c <= 8) ? 4'b0100 : 4'b0000;
      exp_a = (c == 2 || c == 3 || c == 7 || c == 8) ? 4'b0100 : 4'b0000;
      checks++;
      if (grant !== exp_g || ack !== exp_a || busy !== (c >= 2 && c <= 9)) begin
        errors++;
        $display("[TB] FAIL bp_c%0d: grant=%b ack=%b busy=%b, required grant=%b ack=%b",
                 c, grant, ack, busy, exp_g, exp_a);
      end
      if (c >= 4 && c <= 6) begin
        checks++;
        if (fifo_inc !== 1'b0 || fifo_din !== 8'hC2) begin
          errors++;
          $display("[TB] FAIL bp_stall_c%0d: inc=%b din=%h, required inc=0 din=c2", c, fifo_inc, fifo_din);
        end
      end
    end
    drain("bp");
  endtask

  task automatic test_reset_mid_burst();
    clear_queues();
    for (int k = 0; k < 6; k++) push_word(1, DWIDTH'(8'h50 + k));
    for (int c = 1; c <= 4; c++) cycle(1'b0);
    checks++;
    if (ack !== 4'b0010 || fifo_din !== 8'h52) begin
      errors++;
      $display("[TB] FAIL mid_third_word: ack=%b din=%h, required ack=0010 din=52", ack, fifo_din);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (grant !== '0 || fifo_inc !== 1'b0 || ack !== '0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_async_clear: grant=%b inc=%b ack=%b busy=%b, required all 0",
               grant, fifo_inc, ack, busy);
    end
    clear_queues();
    push_word(1, 8'h61); push_word(1, 8'h62);
    push_word(3, 8'h81); push_word(3, 8'h82);
    cycle(1'b0);
    checks++;
    if (grant !== '0) begin
      errors++;
      $display("[TB] FAIL mid_held_reset: grant=%b, required 0000", grant);
    end
    reset = 1'b0;
    cycle(1'b0);
    checks++;
    if (grant !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL mid_first_grant: grant=%b, required 0010", grant);
    end
    drain("mid");
  endtask

  initial begin
    test_reset();
    test_idle();
    test_round_robin();
    test_early_release();
    test_single();
    test_back_pressure();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
